// File: rtl/simon_pkg.sv
// Shared state encoding and constant-width helpers for the Simon engine slice.
package simon_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_LISTEN,
        S_WIN,
        S_LOSE
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(v))) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/simon_engine_if.sv
// Player/rng inputs and LED/score outputs of the Simon engine, grouped as one bundle.
interface simon_engine_if #(
    parameter int unsigned NUM_BUTTONS = 4,
    parameter int unsigned DEPTH       = 16
);
    import simon_pkg::*;

    localparam int unsigned BTN_W = clog2(NUM_BUTTONS);
    localparam int unsigned LVL_W = clog2(DEPTH + 1);

    logic                   i_tick;
    logic                   i_start;
    logic [BTN_W-1:0]       i_rand;
    logic [BTN_W-1:0]       i_in_btn;
    logic                   i_in_valid;
    logic [NUM_BUTTONS-1:0] o_led;
    logic                   o_win;
    logic                   o_lose;
    logic                   o_hs;
    logic [LVL_W-1:0]       o_level;
    logic [LVL_W-1:0]       o_high_score;

    modport slave (
        input  i_tick, i_start, i_rand, i_in_btn, i_in_valid,
        output o_led, o_win, o_lose, o_hs, o_level, o_high_score
    );

    modport master (
        output i_tick, i_start, i_rand, i_in_btn, i_in_valid,
        input  o_led, o_win, o_lose, o_hs, o_level, o_high_score
    );

endinterface

// File: rtl/simon_seq_mem.sv
// Sequence store: register file with one synchronous write port and one async read port.
module simon_seq_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simon_engine.sv
// Simon game engine: grows a random sequence, replays it on one-hot LEDs paced by tick,
// checks player presses with a per-press timeout, and tracks level and high score.
module simon_engine
    import simon_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS   = 4,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ON_TICKS      = 4,
    parameter int unsigned OFF_TICKS     = 2,
    parameter int unsigned TIMEOUT_TICKS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    simon_engine_if.slave  bus
);

    localparam int unsigned BTN_W  = clog2(NUM_BUTTONS);
    localparam int unsigned LVL_W  = clog2(DEPTH + 1);
    localparam int unsigned ADDR_W = (clog2(DEPTH) == 0) ? 1 : clog2(DEPTH);
    localparam int unsigned CNT_W  = clog2(max3(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS) + 1);

    state_t                 r_state;
    logic                   r_start_d;
    logic [LVL_W-1:0]       r_level;
    logic [LVL_W-1:0]       r_idx;
    logic [LVL_W-1:0]       r_high_score;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_BUTTONS-1:0] r_led;
    logic                   r_win;
    logic                   r_lose;
    logic                   r_hs;

    logic                   w_start_rise;
    logic [BTN_W:0]         w_rand_ext;
    logic [BTN_W-1:0]       w_fold;
    logic [BTN_W-1:0]       w_rd_data;
    logic                   w_we;
    logic                   w_idx_last;
    logic [LVL_W-1:0]       w_lose_score;
    logic                   w_lose_new_hs;
    logic                   w_win_new_hs;
    logic [NUM_BUTTONS-1:0] w_echo;

    function automatic logic [NUM_BUTTONS-1:0] onehot(input logic [BTN_W-1:0] b);
        return NUM_BUTTONS'(1) << b;
    endfunction

    assign w_start_rise  = bus.i_start & ~r_start_d;
    assign w_rand_ext    = (BTN_W+1)'(bus.i_rand);
    assign w_fold        = (w_rand_ext >= (BTN_W+1)'(NUM_BUTTONS))
                           ? BTN_W'(w_rand_ext - (BTN_W+1)'(NUM_BUTTONS)) : bus.i_rand;
    assign w_we          = (r_state == S_APPEND);
    assign w_idx_last    = ((r_idx + LVL_W'(1)) == r_level);
    assign w_lose_score  = r_level - LVL_W'(1);
    assign w_lose_new_hs = (w_lose_score > r_high_score);
    assign w_win_new_hs  = (LVL_W'(DEPTH) > r_high_score);
    assign w_echo        = ((r_state == S_LISTEN) && bus.i_in_valid) ? onehot(bus.i_in_btn) : '0;

    simon_seq_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (BTN_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_level[ADDR_W-1:0]),
        .i_wdata (w_fold),
        .i_raddr (r_idx[ADDR_W-1:0]),
        .o_rdata (w_rd_data)
    );

    // idx advances when a step goes dark, so during SHOW_OFF the async read already
    // presents the next step and its LED can be registered on the SHOW_OFF exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_start_d    <= 1'b0;
            r_level      <= '0;
            r_idx        <= '0;
            r_high_score <= '0;
            r_cnt        <= '0;
            r_led        <= '0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
            r_hs         <= 1'b0;
        end else begin
            r_start_d <= bus.i_start;
            case (r_state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (w_start_rise) begin
                        r_win   <= 1'b0;
                        r_lose  <= 1'b0;
                        r_hs    <= 1'b0;
                        r_level <= '0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_APPEND;
                    end
                end
                S_APPEND: begin
                    // mem[0] is being written this cycle on the first round; bypass it.
                    r_led   <= onehot((r_level == '0) ? w_fold : w_rd_data);
                    r_level <= r_level + LVL_W'(1);
                    r_idx   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (bus.i_tick) begin
                        if (r_cnt == CNT_W'(ON_TICKS - 1)) begin
                            r_cnt   <= '0;
                            r_led   <= '0;
                            r_idx   <= r_idx + LVL_W'(1);
                            r_state <= S_SHOW_OFF;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_SHOW_OFF: begin
                    if (bus.i_tick) begin
                        if (r_cnt == CNT_W'(OFF_TICKS - 1)) begin
                            r_cnt <= '0;
                            if (r_idx == r_level) begin
                                r_idx   <= '0;
                                r_state <= S_LISTEN;
                            end else begin
                                r_led   <= onehot(w_rd_data);
                                r_state <= S_SHOW_ON;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_LISTEN: begin
                    if (bus.i_in_valid) begin
                        r_cnt <= '0;
                        if (bus.i_in_btn != w_rd_data) begin
                            r_lose  <= 1'b1;
                            r_state <= S_LOSE;
                            if (w_lose_new_hs) begin
                                r_high_score <= w_lose_score;
                                r_hs         <= 1'b1;
                            end
                        end else if (w_idx_last) begin
                            r_idx <= '0;
                            if (r_level == LVL_W'(DEPTH)) begin
                                r_win   <= 1'b1;
                                r_state <= S_WIN;
                                if (w_win_new_hs) begin
                                    r_high_score <= LVL_W'(DEPTH);
                                    r_hs         <= 1'b1;
                                end
                            end else begin
                                r_state <= S_APPEND;
                            end
                        end else begin
                            r_idx <= r_idx + LVL_W'(1);
                        end
                    end else if (bus.i_tick) begin
                        if (r_cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
                            r_cnt   <= '0;
                            r_lose  <= 1'b1;
                            r_state <= S_LOSE;
                            if (w_lose_new_hs) begin
                                r_high_score <= w_lose_score;
                                r_hs         <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Echo is shown in the strobe cycle itself; playback LEDs are registered.
    assign bus.o_led        = r_led | w_echo;
    assign bus.o_win        = r_win;
    assign bus.o_lose       = r_lose;
    assign bus.o_hs         = r_hs;
    assign bus.o_level      = r_level;
    assign bus.o_high_score = r_high_score;

endmodule

// File: tb/tb_simon_engine.sv
// Directed bench for simon_engine: 4-button DEPTH=4 instance plus a 3-button instance.
module tb_simon_engine;
    import simon_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rst3_n;
    int   checks   = 0;
    int   failures = 0;
    logic [1:0] seq [4];

    always #5 clk = ~clk;

    simon_engine_if #(.NUM_BUTTONS(4), .DEPTH(4)) bus ();
    simon_engine_if #(.NUM_BUTTONS(3), .DEPTH(4)) bus3 ();

    simon_engine #(.NUM_BUTTONS(4), .DEPTH(4), .ON_TICKS(2), .OFF_TICKS(1),
                   .TIMEOUT_TICKS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    simon_engine #(.NUM_BUTTONS(3), .DEPTH(4), .ON_TICKS(2), .OFF_TICKS(1),
                   .TIMEOUT_TICKS(8)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3));

    task automatic tick1();
        bus.i_tick = 1'b1;
        @(negedge clk);
        bus.i_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    task automatic press(input logic [1:0] b);
        bus.i_in_valid = 1'b1;
        bus.i_in_btn   = b;
        @(negedge clk);
        bus.i_in_valid = 1'b0;
    endtask

    task automatic start_game(input logic [1:0] r);
        bus.i_start = 1'b1;
        bus.i_rand  = r;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst3_n = 1'b0;
        bus.i_tick = 0; bus.i_start = 0; bus.i_rand = 0; bus.i_in_btn = 0; bus.i_in_valid = 0;
        bus3.i_tick = 0; bus3.i_start = 0; bus3.i_rand = 0; bus3.i_in_btn = 0; bus3.i_in_valid = 0;
        repeat (3) @(negedge clk);
        if (bus.o_level !== 3'd0) begin $display("FAIL rst_level_in_reset got=%0d exp=0", bus.o_level); failures++; end checks++;
        rst_n = 1'b1; rst3_n = 1'b1;
        ticks(20);
        if (bus.o_led !== 4'b0000) begin $display("FAIL idle_led got=%b exp=0000", bus.o_led); failures++; end checks++;
        if (bus.o_win !== 1'b0) begin $display("FAIL idle_win got=%b exp=0", bus.o_win); failures++; end checks++;
        if (bus.o_lose !== 1'b0) begin $display("FAIL idle_lose got=%b exp=0", bus.o_lose); failures++; end checks++;
        if (bus.o_hs !== 1'b0) begin $display("FAIL idle_hs got=%b exp=0", bus.o_hs); failures++; end checks++;
        if (bus.o_level !== 3'd0) begin $display("FAIL idle_level got=%0d exp=0", bus.o_level); failures++; end checks++;
        if (bus.o_high_score !== 3'd0) begin $display("FAIL idle_high_score got=%0d exp=0", bus.o_high_score); failures++; end checks++;
    endtask

    task automatic test_playback();
        start_game(2'd2);
        if (bus.o_level !== 3'd1) begin $display("FAIL r1_level got=%0d exp=1", bus.o_level); failures++; end checks++;
        if (bus.o_led !== 4'b0100) begin $display("FAIL r1_led_first_cycle got=%b exp=0100", bus.o_led); failures++; end checks++;
        // press and start edge during playback must both be ignored
        bus.i_in_valid = 1'b1; bus.i_in_btn = 2'd3; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_in_valid = 1'b0; bus.i_start = 1'b0;
        if (bus.o_lose !== 1'b0) begin $display("FAIL ignore_press_lose got=%b exp=0", bus.o_lose); failures++; end checks++;
        if (bus.o_level !== 3'd1) begin $display("FAIL ignore_start_level got=%0d exp=1", bus.o_level); failures++; end checks++;
        ticks(1);
        if (bus.o_led !== 4'b0100) begin $display("FAIL r1_led_tick1 got=%b exp=0100", bus.o_led); failures++; end checks++;
        ticks(1);
        if (bus.o_led !== 4'b0000) begin $display("FAIL r1_led_off got=%b exp=0000", bus.o_led); failures++; end checks++;
        ticks(1);
        bus.i_in_valid = 1'b1; bus.i_in_btn = 2'd2; bus.i_rand = 2'd1;
        #1;
        if (bus.o_led !== 4'b0100) begin $display("FAIL echo_led got=%b exp=0100", bus.o_led); failures++; end checks++;
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        @(negedge clk);
        if (bus.o_level !== 3'd2) begin $display("FAIL r2_level got=%0d exp=2", bus.o_level); failures++; end checks++;
        if (bus.o_led !== 4'b0100) begin $display("FAIL r2_step0_led got=%b exp=0100", bus.o_led); failures++; end checks++;
        ticks(2);
        if (bus.o_led !== 4'b0000) begin $display("FAIL r2_gap_led got=%b exp=0000", bus.o_led); failures++; end checks++;
        ticks(1);
        if (bus.o_led !== 4'b0010) begin $display("FAIL r2_step1_led got=%b exp=0010", bus.o_led); failures++; end checks++;
        ticks(3);
    endtask

    task automatic test_lose();
        press(2'd2);
        if (bus.o_lose !== 1'b0) begin $display("FAIL r2_good_press_lose got=%b exp=0", bus.o_lose); failures++; end checks++;
        press(2'd3);
        if (bus.o_lose !== 1'b1) begin $display("FAIL mismatch_lose got=%b exp=1", bus.o_lose); failures++; end checks++;
        if (bus.o_level !== 3'd2) begin $display("FAIL lose_level got=%0d exp=2", bus.o_level); failures++; end checks++;
        if (bus.o_high_score !== 3'd1) begin $display("FAIL lose_high_score got=%0d exp=1", bus.o_high_score); failures++; end checks++;
        if (bus.o_hs !== 1'b1) begin $display("FAIL lose_hs got=%b exp=1", bus.o_hs); failures++; end checks++;
        start_game(2'd0);
        if (bus.o_lose !== 1'b0) begin $display("FAIL restart_lose_clear got=%b exp=0", bus.o_lose); failures++; end checks++;
        if (bus.o_led !== 4'b0001) begin $display("FAIL restart_led got=%b exp=0001", bus.o_led); failures++; end checks++;
        ticks(3);
        press(2'd3);
        if (bus.o_lose !== 1'b1) begin $display("FAIL r1_lose got=%b exp=1", bus.o_lose); failures++; end checks++;
        if (bus.o_hs !== 1'b0) begin $display("FAIL r1_lose_hs got=%b exp=0", bus.o_hs); failures++; end checks++;
        if (bus.o_high_score !== 3'd1) begin $display("FAIL r1_lose_high_score got=%0d exp=1", bus.o_high_score); failures++; end checks++;
    endtask

    task automatic test_win();
        logic [3:0] exp_led;
        seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd2; seq[3] = 2'd1;
        start_game(seq[0]);
        for (int k = 1; k <= 4; k++) begin
            if (bus.o_level !== 3'(k)) begin $display("FAIL win_round_level got=%0d exp=%0d", bus.o_level, k); failures++; end checks++;
            for (int s = 0; s < k; s++) begin
                exp_led = 4'b0001 << seq[s];
                if (bus.o_led !== exp_led) begin $display("FAIL win_show_led round=%0d step=%0d got=%b exp=%b", k, s, bus.o_led, exp_led); failures++; end checks++;
                ticks(3);
            end
            for (int s = 0; s < k; s++) begin
                if (s == k - 1 && k < 4) bus.i_rand = seq[k];
                press(seq[s]);
            end
            if (k < 4) @(negedge clk);
        end
        if (bus.o_win !== 1'b1) begin $display("FAIL win_flag got=%b exp=1", bus.o_win); failures++; end checks++;
        if (bus.o_high_score !== 3'd4) begin $display("FAIL win_high_score got=%0d exp=4", bus.o_high_score); failures++; end checks++;
        if (bus.o_hs !== 1'b1) begin $display("FAIL win_hs got=%b exp=1", bus.o_hs); failures++; end checks++;
        if (bus.o_level !== 3'd4) begin $display("FAIL win_level got=%0d exp=4", bus.o_level); failures++; end checks++;
        start_game(2'd1);
        if (bus.o_win !== 1'b0) begin $display("FAIL win_restart_clear got=%b exp=0", bus.o_win); failures++; end checks++;
        if (bus.o_level !== 3'd1) begin $display("FAIL win_restart_level got=%0d exp=1", bus.o_level); failures++; end checks++;
    endtask

    task automatic test_timeout();
        ticks(3);
        ticks(7);
        if (bus.o_lose !== 1'b0) begin $display("FAIL timeout_early got=%b exp=0", bus.o_lose); failures++; end checks++;
        ticks(1);
        if (bus.o_lose !== 1'b1) begin $display("FAIL timeout_lose got=%b exp=1", bus.o_lose); failures++; end checks++;
        if (bus.o_high_score !== 3'd4) begin $display("FAIL timeout_high_score got=%0d exp=4", bus.o_high_score); failures++; end checks++;
        start_game(2'd2);
        ticks(3);
        ticks(7);
        bus.i_rand = 2'd3; bus.i_tick = 1'b1; bus.i_in_valid = 1'b1; bus.i_in_btn = 2'd2;
        @(negedge clk);
        bus.i_tick = 1'b0; bus.i_in_valid = 1'b0;
        if (bus.o_lose !== 1'b0) begin $display("FAIL coincident_press_lose got=%b exp=0", bus.o_lose); failures++; end checks++;
        @(negedge clk);
        if (bus.o_level !== 3'd2) begin $display("FAIL coincident_level got=%0d exp=2", bus.o_level); failures++; end checks++;
        if (bus.o_led !== 4'b0100) begin $display("FAIL coincident_led got=%b exp=0100", bus.o_led); failures++; end checks++;
        #2 rst_n = 1'b0;
        #1;
        if (bus.o_led !== 4'b0000) begin $display("FAIL async_rst_led got=%b exp=0000", bus.o_led); failures++; end checks++;
        if (bus.o_level !== 3'd0) begin $display("FAIL async_rst_level got=%0d exp=0", bus.o_level); failures++; end checks++;
        if (bus.o_high_score !== 3'd0) begin $display("FAIL async_rst_high_score got=%0d exp=0", bus.o_high_score); failures++; end checks++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_three_buttons();
        bus3.i_start = 1'b1; bus3.i_rand = 2'd3;
        @(negedge clk);
        bus3.i_start = 1'b0;
        @(negedge clk);
        if (bus3.o_led !== 3'b001) begin $display("FAIL nb3_fold_led got=%b exp=001", bus3.o_led); failures++; end checks++;
        if (bus3.o_level !== 3'd1) begin $display("FAIL nb3_level got=%0d exp=1", bus3.o_level); failures++; end checks++;
        bus3.i_tick = 1'b1;
        @(negedge clk);
        bus3.i_tick = 1'b0;
        #2 rst3_n = 1'b0;
        #1;
        if (bus3.o_led !== 3'b000) begin $display("FAIL nb3_rst_led got=%b exp=000", bus3.o_led); failures++; end checks++;
        if (bus3.o_level !== 3'd0) begin $display("FAIL nb3_rst_level got=%0d exp=0", bus3.o_level); failures++; end checks++;
        if ({bus3.o_win, bus3.o_lose, bus3.o_hs} !== 3'b000) begin $display("FAIL nb3_rst_flags got=%b exp=000", {bus3.o_win, bus3.o_lose, bus3.o_hs}); failures++; end checks++;
        @(negedge clk);
        rst3_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_playback();
        test_lose();
        test_win();
        test_timeout();
        test_three_buttons();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
